pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register carrying a control and a
// data payload. SKID_EN=1 gives a 2-entry skid buffer with a registered
// in_ready; SKID_EN=0 gives a single entry with a combinational in_ready.
// Idle or flushed stages present an all-zero control word (a NOP).
module pipe_stage_reg #(
  parameter int unsigned CTRL_W  = 12,
  parameter int unsigned DATA_W  = 200,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rdy_q;
  logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] head_data_q, skid_data_q;
  logic              head_load_in, head_load_skid, skid_load;
  logic              in_xfer, out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // rdy_q tracks (state != FULL) and is 0 in reset. With SKID_EN=0 the state
  // never reaches FULL, so rdy_q doubles as the "out of reset" qualifier for
  // the combinational ready.
  assign in_ready  = SKID_EN ? rdy_q : (rdy_q && (!out_valid || out_ready));

  assign out_ctrl  = out_valid ? head_ctrl_q : '0;
  assign out_data  = head_data_q;
  assign occupancy = state_q;

  // Next-state and register-load decode; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d      = ONE;
            head_load_in = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_load_in = 1'b1;
          end else if (in_xfer) begin
            if (SKID_EN) begin
              state_d   = FULL;
              skid_load = 1'b1;
            end
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d        = ONE;
            head_load_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register and registered ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  // Control payload: cleared by flush so a killed head can never leak out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      head_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (head_load_in)        head_ctrl_q <= in_ctrl;
      else if (head_load_skid) head_ctrl_q <= skid_ctrl_q;
      if (skid_load)           skid_ctrl_q <= in_ctrl;
    end
  end

  // Data payload: only written on loads, left untouched by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      if (head_load_in)        head_data_q <= in_data;
      else if (head_load_skid) head_data_q <= skid_data_q;
      if (skid_load)           skid_data_q <= in_data;
    end
  end

  // Saturating count of cycles where downstream was ready but nothing offered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (!out_valid && out_ready && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (default parameters, skid enabled).
// Accepted inputs are pushed to a scoreboard queue and popped on each output
// transfer; a bench-side counter models bubble_cnt.
module tb_pipe_stage_reg;

  localparam int CW = 12;
  localparam int DW = 200;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   bubble_cnt;

  logic [CW+DW-1:0] sb[$];
  int               errors;
  int               checks;
  int               n_out;
  logic [15:0]      exp_bub;
  logic             last_in_acc;

  pipe_stage_reg #(
    .CTRL_W (CW),
    .DATA_W (DW),
    .SKID_EN(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < 7; i++) d = (d << 32) | DW'($urandom);
    return d;
  endfunction

  function automatic logic [CW-1:0] rand_ctrl();
    return CW'($urandom) | CW'(1);
  endfunction

  // One clock cycle, entered and left at a falling edge. Observes transfers
  // #1 after driving, updates the scoreboard, then checks bubble_cnt.
  task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl);
    logic [CW+DW-1:0] exp;
    in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl;
    #1;
    last_in_acc = iv && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ctrl=%h data=%h, want no output", out_ctrl, out_data);
      end else begin
        exp = sb.pop_front();
        if ({out_ctrl, out_data} !== exp) begin
          errors++;
          $display("FAIL sb_order: got ctrl=%h data=%h, want ctrl=%h data=%h",
                   out_ctrl, out_data, exp[CW+DW-1:DW], exp[DW-1:0]);
        end
      end
    end
    if (!out_valid) begin
      checks++;
      if (out_ctrl !== '0) begin
        errors++;
        $display("FAIL nop_ctrl: got %h want 0", out_ctrl);
      end
    end
    if (!out_valid && out_ready && exp_bub != 16'hFFFF) exp_bub++;
    if (fl) sb.delete();
    else if (last_in_acc) sb.push_back({ic, id});
    @(negedge clk);
    checks++;
    if (bubble_cnt !== exp_bub) begin
      errors++;
      $display("FAIL bubble_cnt: got %0d want %0d", bubble_cnt, exp_bub);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: got pending=%0d out_valid=%b want 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    exp_bub = '0;
    #3;
    checks++;
    if ({out_valid, out_ctrl, out_data, occupancy, bubble_cnt, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b c=%h occ=%0d bub=%0d rdy=%b, want all 0",
               out_valid, out_ctrl, occupancy, bubble_cnt, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_pre_edge: got %b want 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_rdy_post_edge: got rdy=%b occ=%0d want 1/0", in_ready, occupancy);
    end
  endtask

  task automatic test_single_pass();
    logic [DW-1:0] d0;
    d0 = rand_data();
    cycle(1'b1, 12'h0A5, d0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 12'h0A5 || out_data !== d0) begin
      errors++;
      $display("FAIL single_out: got v=%b c=%h d=%h want 1/0a5/%h", out_valid, out_ctrl, out_data, d0);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      errors++;
      $display("FAIL single_after: got v=%b c=%h want 0/000", out_valid, out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] c[3];
    logic [DW-1:0] d[3];
    int            n0;
    for (int i = 0; i < 3; i++) begin c[i] = rand_ctrl(); d[i] = rand_data(); end
    n0 = n_out;
    cycle(1'b1, c[0], d[0], 1'b0, 1'b0);
    checks++;
    if (occupancy !== 2'd1) begin
      errors++; $display("FAIL bp_occ1: got %0d want 1", occupancy);
    end
    cycle(1'b1, c[1], d[1], 1'b0, 1'b0);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: got occ=%0d rdy=%b want 2/0", occupancy, in_ready);
    end
    cycle(1'b1, c[2], d[2], 1'b0, 1'b0);
    checks++;
    if (last_in_acc !== 1'b0 || occupancy !== 2'd2) begin
      errors++; $display("FAIL bp_hold: got acc=%b occ=%0d want 0/2", last_in_acc, occupancy);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, c[2], d[2], 1'b1, 1'b0);
      if (last_in_acc) break;
    end
    checks++;
    if (last_in_acc !== 1'b1) begin
      errors++; $display("FAIL bp_accept_timeout: got acc=0 want 1");
    end
    drain();
    checks++;
    if (n_out - n0 != 3) begin
      errors++; $display("FAIL bp_count: got %0d outputs want 3", n_out - n0);
    end
  endtask

  task automatic test_full_throughput();
    int          n0;
    int          bad_occ;
    logic [15:0] bub0;
    n0 = n_out;
    bad_occ = 0;
    cycle(1'b1, rand_ctrl(), rand_data(), 1'b1, 1'b0);
    bub0 = exp_bub;
    if (occupancy !== 2'd1) bad_occ++;
    for (int i = 1; i < 100; i++) begin
      cycle(1'b1, rand_ctrl(), rand_data(), 1'b1, 1'b0);
      if (occupancy !== 2'd1) bad_occ++;
    end
    checks++;
    if (bad_occ != 0) begin
      errors++; $display("FAIL tp_occ: got %0d cycles with occ!=1 want 0", bad_occ);
    end
    checks++;
    if (bubble_cnt !== bub0) begin
      errors++; $display("FAIL tp_bubble: got %0d want %0d", bubble_cnt, bub0);
    end
    drain();
    checks++;
    if (n_out - n0 != 100) begin
      errors++; $display("FAIL tp_count: got %0d outputs want 100", n_out - n0);
    end
  endtask

  task automatic test_flush();
    int n0;
    cycle(1'b1, rand_ctrl(), rand_data(), 1'b0, 1'b0);
    cycle(1'b1, rand_ctrl(), rand_data(), 1'b0, 1'b0);
    n0 = n_out;
    cycle(1'b1, rand_ctrl(), rand_data(), 1'b0, 1'b1);
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: got occ=%0d v=%b c=%h rdy=%b want 0/0/000/1",
               occupancy, out_valid, out_ctrl, in_ready);
    end
    drain();
    checks++;
    if (n_out != n0) begin
      errors++; $display("FAIL flush_leak: got %0d outputs want 0", n_out - n0);
    end
    cycle(1'b1, rand_ctrl(), rand_data(), 1'b1, 1'b0);
    n0 = n_out;
    cycle(1'b1, rand_ctrl(), rand_data(), 1'b1, 1'b1);
    checks++;
    if (n_out - n0 != 1 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_with_out: got outputs=%0d occ=%0d want 1/0", n_out - n0, occupancy);
    end
    n0 = n_out;
    drain();
    checks++;
    if (n_out != n0) begin
      errors++; $display("FAIL flush_replay: got %0d outputs want 0", n_out - n0);
    end
  endtask

  task automatic test_reset_midstream();
    logic [CW-1:0] cn;
    logic [DW-1:0] dn;
    cycle(1'b1, rand_ctrl(), rand_data(), 1'b0, 1'b0);
    cycle(1'b1, rand_ctrl(), rand_data(), 1'b0, 1'b0);
    checks++;
    if (occupancy !== 2'd2) begin
      errors++; $display("FAIL rst_mid_fill: got occ=%0d want 2", occupancy);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_ctrl, out_data, occupancy, bubble_cnt, in_ready} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got v=%b c=%h occ=%0d bub=%0d rdy=%b want all 0",
               out_valid, out_ctrl, occupancy, bubble_cnt, in_ready);
    end
    sb.delete();
    exp_bub = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_rdy: got %b want 1", in_ready);
    end
    cn = rand_ctrl(); dn = rand_data();
    cycle(1'b1, cn, dn, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== cn || out_data !== dn) begin
      errors++;
      $display("FAIL rst_mid_first: got v=%b c=%h d=%h want 1/%h/%h", out_valid, out_ctrl, out_data, cn, dn);
    end
    drain();
  endtask

  task automatic test_bubble_saturation();
    for (int i = 0; i < 70000; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL bub_sat: got %h want ffff", bubble_cnt);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL bub_hold: got %h want ffff", bubble_cnt);
    end
  endtask

  initial begin
    errors = 0; checks = 0; n_out = 0; last_in_acc = 1'b0;
    test_reset();
    test_single_pass();
    test_backpressure();
    test_full_throughput();
    test_flush();
    test_reset_midstream();
    test_bubble_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
